// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-port (instruction/data) arbiter in front of a synchronous
//            16-bit x 512 memory; IDLE/ISSUE/WAIT/ACK FSM, registered outputs.
//            Optional macro ARB_ROUND_ROBIN_EN: round-robin on a tie,
//            otherwise port 1 has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [8:0]  addr0,
    input  logic [8:0]  addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] rdata0,
    output logic [15:0] rdata1,
    output logic        mem_rn,
    output logic        mem_wn,
    output logic [8:0]  mem_addr,
    output logic [15:0] mem_din,
    input  logic [15:0] mem_dout,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_port;
    logic        r_we;

    logic        w_any;
    logic        w_grant;
    logic        w_we;
    logic [8:0]  w_addr;
    logic [15:0] w_wdata;

    assign w_any = req0 | req1;

`ifdef ARB_ROUND_ROBIN_EN
    // Last port granted; starts at port 1 so the first tie goes to port 0.
    logic r_last;
    assign w_grant = (req0 && req1) ? ~r_last : req1;
`else
    assign w_grant = req1;
`endif

    assign w_we    = w_grant ? we1    : we0;
    assign w_addr  = w_grant ? addr1  : addr0;
    assign w_wdata = w_grant ? wdata1 : wdata0;

    // mem_addr/mem_din double as the latched request address/data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_port   <= 1'b0;
            r_we     <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rdata0   <= 16'h0000;
            rdata1   <= 16'h0000;
            mem_rn   <= 1'b0;
            mem_wn   <= 1'b0;
            mem_addr <= 9'd0;
            mem_din  <= 16'h0000;
            busy     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last   <= 1'b1;
`endif
        end else begin
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            mem_rn <= 1'b0;
            mem_wn <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_port   <= w_grant;
                        r_we     <= w_we;
                        mem_addr <= w_addr;
                        mem_din  <= w_wdata;
                        mem_rn   <= ~w_we;
                        mem_wn   <= w_we;
                        busy     <= 1'b1;
                        r_state  <= S_ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
                        r_last   <= w_grant;
`endif
                    end
                end
                S_ISSUE: begin
                    if (r_we) begin
                        ack0    <= ~r_port;
                        ack1    <= r_port;
                        r_state <= S_ACK;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_port) begin
                        rdata1 <= mem_dout;
                    end else begin
                        rdata0 <= mem_dout;
                    end
                    ack0    <= ~r_port;
                    ack1    <= r_port;
                    r_state <= S_ACK;
                end
                S_ACK: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
